// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - command sequencer driving a 4-bit universal shift register
// Optional feature macro: SHSEQ_SOUT_COUNT_EN (count 1s seen on S_OUT while shifting).
module shift_reg_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_DIR,
    input  logic             CMD_SIN,
    input  logic [3:0]       CMD_DATA,
    input  logic [CNT_W-1:0] CMD_COUNT,
    output logic             ENB,
    output logic             DIR,
    output logic             S_IN,
    output logic [1:0]       MODO,
    output logic [3:0]       D,
    input  logic [3:0]       Q,
    input  logic             S_OUT,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [3:0]       RSP_Q,
    output logic [CNT_W-1:0] RSP_SOUT_CNT
);

    localparam logic [1:0] OP_SHIFT  = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;
    localparam logic [1:0] MODO_LOAD = 2'b10;
    localparam logic [1:0] MODO_HOLD = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic             dir_q;
    logic             sin_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       d_q;
    logic [3:0]       rsp_q_q;
    logic             accept;

    assign accept = (state == S_IDLE) && CMD_VALID;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    state_nxt = (CMD_OP == OP_READ) ? S_CAPTURE : S_LOAD;
                end
            end
            S_LOAD: begin
                if ((op_q == OP_LOAD) || (count_q == '0)) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command fields are latched once at accept; the register interface is
    // driven only from these copies so CMD_* never reaches it combinationally.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q    <= OP_READ;
            dir_q   <= 1'b0;
            sin_q   <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            op_q    <= CMD_OP;
            dir_q   <= CMD_DIR;
            sin_q   <= CMD_SIN;
            count_q <= CMD_COUNT;
        end
    end

    // D only changes when a load is about to happen, so it holds between commands.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            d_q <= 4'b0000;
        end else if (accept && (CMD_OP != OP_READ)) begin
            d_q <= CMD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (state == S_LOAD) begin
            cnt_q <= count_q;
        end else if ((state == S_SHIFT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rsp_q_q <= 4'b0000;
        end else if (state == S_CAPTURE) begin
            rsp_q_q <= Q;
        end
    end

`ifdef SHSEQ_SOUT_COUNT_EN
    logic [CNT_W-1:0] sout_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sout_cnt_q <= '0;
        end else if (accept) begin
            sout_cnt_q <= '0;
        end else if ((state == S_SHIFT) && S_OUT && (sout_cnt_q != CNT_MAX)) begin
            sout_cnt_q <= sout_cnt_q + CNT_ONE;
        end
    end

    assign RSP_SOUT_CNT = sout_cnt_q;
`else
    logic unused_sout;

    assign unused_sout  = S_OUT;
    assign RSP_SOUT_CNT = '0;
`endif

    always_comb begin
        CMD_READY = 1'b0;
        ENB       = 1'b0;
        MODO      = MODO_HOLD;
        DIR       = 1'b0;
        S_IN      = 1'b0;
        RSP_VALID = 1'b0;
        case (state)
            S_IDLE: begin
                CMD_READY = 1'b1;
            end
            S_LOAD: begin
                ENB  = 1'b1;
                MODO = MODO_LOAD;
            end
            S_SHIFT: begin
                ENB  = 1'b1;
                MODO = op_q;
                DIR  = dir_q;
                S_IN = (op_q == OP_SHIFT) ? sin_q : 1'b0;
            end
            S_RESP: begin
                RSP_VALID = 1'b1;
            end
            default: begin
                ENB = 1'b0;
            end
        endcase
    end

    assign D     = d_q;
    assign RSP_Q = rsp_q_q;

endmodule
